// File: rtl/mem_access_sequencer.sv
// MEM-stage front end for the byte-addressed data memory: aligned accesses pass through combinationally,
// misaligned ones become N stalled byte accesses plus one DONE cycle; out-of-range/disallowed accesses fault.
module mem_access_sequencer #(
  parameter int unsigned MEM_BYTES        = 16384,
  parameter int unsigned ALLOW_MISALIGNED = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        access_fault,
  output logic        dm_mem_read,
  output logic        dm_mem_write,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [31:0] dm_instruction,
  input  logic [31:0] dm_rdata
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SPLIT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic        ALLOW    = (ALLOW_MISALIGNED != 0);
  localparam logic [32:0] MEM_SIZE = 33'(MEM_BYTES);

  logic [1:0]  state;
  logic [1:0]  cnt;
  logic [31:0] asm_reg;
  logic [1:0]  last_q;
  logic [2:0]  f3_q;
  logic        store_q;

  logic        is_store;
  logic        is_load;
  logic        f3_ok_st;
  logic        f3_ok_ld;
  logic        access_ok;
  logic [2:0]  size_n;
  logic [32:0] last_addr;
  logic        in_range;
  logic        aligned;
  logic        fault_c;
  logic        pass_c;
  logic        start_c;
  logic [1:0]  cur_cnt;
  logic [31:0] byte_addr;
  logic [7:0]  wbyte;
  logic [31:0] ext_data;
  logic [2:0]  dm_f3;

  // Both read and write asserted is handled as a store.
  assign is_store = req_valid & req_write;
  assign is_load  = req_valid & req_read & ~req_write;

  assign f3_ok_st  = ~req_funct3[2] & (req_funct3[1:0] != 2'b11);
  assign f3_ok_ld  = (req_funct3[1:0] != 2'b11) & (req_funct3 != 3'b110);
  assign access_ok = (is_store & f3_ok_st) | (is_load & f3_ok_ld);

  always_comb begin
    size_n = 3'd0;
    case (req_funct3[1:0])
      2'b00:   size_n = 3'd1;
      2'b01:   size_n = 3'd2;
      2'b10:   size_n = 3'd4;
      default: size_n = 3'd0;
    endcase
  end

  // 33-bit sum so an access wrapping past 2^32 is caught as out of range.
  assign last_addr = {1'b0, req_addr} + {30'd0, size_n} - 33'd1;
  assign in_range  = (last_addr < MEM_SIZE);
  assign aligned   = (size_n == 3'd1) |
                     ((size_n == 3'd2) & ~req_addr[0]) |
                     ((size_n == 3'd4) & (req_addr[1:0] == 2'b00));

  assign fault_c = (is_store & ~f3_ok_st) |
                   (access_ok & (~in_range | (~aligned & ~ALLOW)));
  assign pass_c  = access_ok & in_range & aligned;
  assign start_c = access_ok & in_range & ~aligned & ALLOW;

  assign cur_cnt   = (state == IDLE) ? 2'd0 : cnt;
  assign byte_addr = req_addr + {30'd0, cur_cnt};
  assign wbyte     = req_wdata[{cur_cnt, 3'b000} +: 8];

  always_comb begin
    ext_data = asm_reg;
    case (f3_q)
      3'b001:  ext_data = {{16{asm_reg[15]}}, asm_reg[15:0]};
      3'b101:  ext_data = {16'd0, asm_reg[15:0]};
      default: ext_data = asm_reg;
    endcase
  end

  always_comb begin
    stall        = 1'b0;
    load_data    = 32'd0;
    load_valid   = 1'b0;
    access_fault = 1'b0;
    dm_mem_read  = 1'b0;
    dm_mem_write = 1'b0;
    dm_addr      = 32'd0;
    dm_wdata     = 32'd0;
    dm_f3        = 3'd0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (!flush) begin
            if (fault_c) begin
              access_fault = 1'b1;
            end else if (pass_c) begin
              dm_mem_read  = is_load;
              dm_mem_write = is_store;
              dm_addr      = req_addr;
              dm_wdata     = req_wdata;
              dm_f3        = req_funct3;
              load_valid   = is_load;
              load_data    = is_load ? dm_rdata : 32'd0;
            end else if (start_c) begin
              stall        = 1'b1;
              dm_mem_read  = is_load;
              dm_mem_write = is_store;
              dm_addr      = byte_addr;
              dm_wdata     = {24'd0, wbyte};
              dm_f3        = is_store ? 3'b000 : 3'b100;
            end
          end
        end
        SPLIT: begin
          // The byte of the flush cycle is still issued; the sequence stops after it.
          stall        = 1'b1;
          dm_mem_read  = ~store_q;
          dm_mem_write = store_q;
          dm_addr      = byte_addr;
          dm_wdata     = {24'd0, wbyte};
          dm_f3        = store_q ? 3'b000 : 3'b100;
        end
        DONE: begin
          if (!store_q && !flush) begin
            load_valid = 1'b1;
            load_data  = ext_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign dm_instruction = {17'd0, dm_f3, 12'd0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 2'd0;
      asm_reg <= 32'd0;
      last_q  <= 2'd0;
      f3_q    <= 3'd0;
      store_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!flush && start_c) begin
            state        <= SPLIT;
            cnt          <= 2'd1;
            last_q       <= (size_n == 3'd4) ? 2'd3 : 2'd1;
            f3_q         <= req_funct3;
            store_q      <= is_store;
            asm_reg[7:0] <= dm_rdata[7:0];
          end
        end
        SPLIT: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            asm_reg[{cnt, 3'b000} +: 8] <= dm_rdata[7:0];
            if (cnt == last_q) state <= DONE;
            else               cnt   <= cnt + 2'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Bench for mem_access_sequencer: byte memory model, load scoreboard, fault/flush/reset scenarios.
module tb_mem_access_sequencer;

  logic        clk;
  logic        rst;
  logic        req_valid, req_read, req_write, flush;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        stall, load_valid, access_fault, dm_mem_read, dm_mem_write;
  logic [31:0] load_data, dm_addr, dm_wdata, dm_instruction, dm_rdata;

  logic        nm_req_valid, nm_req_read, nm_req_write, nm_flush;
  logic [2:0]  nm_req_funct3;
  logic [31:0] nm_req_addr, nm_req_wdata;
  logic        nm_stall, nm_load_valid, nm_access_fault, nm_dm_mem_read, nm_dm_mem_write;
  logic [31:0] nm_load_data, nm_dm_addr, nm_dm_wdata, nm_dm_instruction, nm_dm_rdata;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  mem_access_sequencer #(.MEM_BYTES(16384), .ALLOW_MISALIGNED(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_read(req_read), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush),
    .stall(stall), .load_data(load_data), .load_valid(load_valid), .access_fault(access_fault),
    .dm_mem_read(dm_mem_read), .dm_mem_write(dm_mem_write), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_instruction(dm_instruction), .dm_rdata(dm_rdata));

  mem_access_sequencer #(.MEM_BYTES(16384), .ALLOW_MISALIGNED(0)) dut_nm (
    .clk(clk), .rst(rst), .req_valid(nm_req_valid), .req_read(nm_req_read), .req_write(nm_req_write),
    .req_funct3(nm_req_funct3), .req_addr(nm_req_addr), .req_wdata(nm_req_wdata), .flush(nm_flush),
    .stall(nm_stall), .load_data(nm_load_data), .load_valid(nm_load_valid), .access_fault(nm_access_fault),
    .dm_mem_read(nm_dm_mem_read), .dm_mem_write(nm_dm_mem_write), .dm_addr(nm_dm_addr),
    .dm_wdata(nm_dm_wdata), .dm_instruction(nm_dm_instruction), .dm_rdata(nm_dm_rdata));

  assign nm_dm_rdata = 32'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-addressed data memory with RV32I sized reads/writes.
  logic [7:0]  mem [0:16383];
  logic [13:0] ra;
  logic [7:0]  rb0, rb1, rb2, rb3;
  assign ra  = dm_addr[13:0];
  assign rb0 = mem[ra];
  assign rb1 = mem[ra + 14'd1];
  assign rb2 = mem[ra + 14'd2];
  assign rb3 = mem[ra + 14'd3];

  always_comb begin
    dm_rdata = {rb3, rb2, rb1, rb0};
    case (dm_instruction[14:12])
      3'b000:  dm_rdata = {{24{rb0[7]}}, rb0};
      3'b001:  dm_rdata = {{16{rb1[7]}}, rb1, rb0};
      3'b100:  dm_rdata = {24'd0, rb0};
      3'b101:  dm_rdata = {16'd0, rb1, rb0};
      default: dm_rdata = {rb3, rb2, rb1, rb0};
    endcase
  end

  always @(posedge clk) begin
    if (dm_mem_write) begin
      mem[ra] <= dm_wdata[7:0];
      if (dm_instruction[13:12] != 2'b00) mem[ra + 14'd1] <= dm_wdata[15:8];
      if (dm_instruction[13:12] == 2'b10) begin
        mem[ra + 14'd2] <= dm_wdata[23:16];
        mem[ra + 14'd3] <= dm_wdata[31:24];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Entered and left at a falling edge; holds the request while stall is high.
  task automatic run_req(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] exp_ld,
                         input int exp_stalls, input int exp_lv_cyc);
    int stalls;
    int lv_cyc;
    bit done;
    if (rd && !wr) exp_q.push_back(exp_ld);
    req_valid = 1'b1; req_read = rd; req_write = wr; req_funct3 = f3;
    req_addr = addr; req_wdata = wdata;
    stalls = 0; lv_cyc = 0; done = 1'b0;
    for (int c = 1; c <= 12 && !done; c++) begin
      #2;
      if (load_valid) begin
        lv_cyc = c;
        if (exp_q.size() != 0) chk({tag, "_data"}, load_data, exp_q.pop_front());
        else                   chk({tag, "_spurious_lv"}, 32'(load_valid), 32'd0);
      end
      if (stall) stalls++;
      else       done = 1'b1;
      @(negedge clk);
    end
    req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
    chk({tag, "_completed"}, 32'(done), 32'd1);
    chk({tag, "_stalls"}, 32'(stalls), 32'(exp_stalls));
    if (rd && !wr) chk({tag, "_lv_cycle"}, 32'(lv_cyc), 32'(exp_lv_cyc));
  endtask

  task automatic fault_req(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr);
    req_valid = 1'b1; req_read = rd; req_write = wr; req_funct3 = f3;
    req_addr = addr; req_wdata = 32'hA5A5A5A5;
    #2;
    chk({tag, "_fault"}, 32'(access_fault), 32'd1);
    chk({tag, "_no_dm"}, 32'({dm_mem_read, dm_mem_write}), 32'd0);
    chk({tag, "_no_stall"}, 32'(stall), 32'd0);
    chk({tag, "_no_lv"}, 32'(load_valid), 32'd0);
    @(negedge clk);
    req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
    #2;
    chk({tag, "_pulse_end"}, 32'(access_fault), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0;
    req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    nm_req_valid = 1'b0; nm_req_read = 1'b0; nm_req_write = 1'b0; nm_flush = 1'b0;
    nm_req_funct3 = 3'd0; nm_req_addr = 32'd0; nm_req_wdata = 32'd0;
    repeat (2) @(negedge clk);

    // Outputs forced low while reset is held, even with a live request.
    req_valid = 1'b1; req_read = 1'b1; req_funct3 = 3'b010; req_addr = 32'h100;
    #2;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_dm_read", 32'(dm_mem_read), 32'd0);
    chk("rst_dm_addr", dm_addr, 32'd0);
    chk("rst_lv", 32'(load_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0; req_read = 1'b0;

    // No request: every output idle regardless of other inputs.
    req_write = 1'b1; req_addr = 32'h123; req_wdata = 32'hFFFFFFFF;
    #2;
    chk("idle_dm_write", 32'(dm_mem_write), 32'd0);
    chk("idle_dm_addr", dm_addr, 32'd0);
    chk("idle_dm_wdata", dm_wdata, 32'd0);
    chk("idle_stall", 32'(stall), 32'd0);
    chk("idle_load_data", load_data, 32'd0);
    @(negedge clk);
    req_write = 1'b0;

    run_req("sw_al", 1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'd0, 0, 0);
    run_req("lw_al", 1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 32'hDEADBEEF, 0, 1);

    run_req("sw_mis", 1'b0, 1'b1, 3'b010, 32'h101, 32'h11223344, 32'd0, 4, 0);
    chk("mem_101", 32'(mem[14'h101]), 32'h44);
    chk("mem_102", 32'(mem[14'h102]), 32'h33);
    chk("mem_103", 32'(mem[14'h103]), 32'h22);
    chk("mem_104", 32'(mem[14'h104]), 32'h11);
    run_req("lw_mis", 1'b1, 1'b0, 3'b010, 32'h101, 32'd0, 32'h11223344, 4, 5);

    run_req("sb_203", 1'b0, 1'b1, 3'b000, 32'h203, 32'h00000080, 32'd0, 0, 0);
    run_req("sb_204", 1'b0, 1'b1, 3'b000, 32'h204, 32'h000000FF, 32'd0, 0, 0);
    run_req("lh_mis", 1'b1, 1'b0, 3'b001, 32'h203, 32'd0, 32'hFFFFFF80, 2, 3);
    run_req("lhu_mis", 1'b1, 1'b0, 3'b101, 32'h203, 32'd0, 32'h0000FF80, 2, 3);
    run_req("lb_al", 1'b1, 1'b0, 3'b000, 32'h203, 32'd0, 32'hFFFFFF80, 0, 1);

    // Read and write together behave as a store.
    run_req("rw_st", 1'b1, 1'b1, 3'b010, 32'h108, 32'h55AA55AA, 32'd0, 0, 0);
    run_req("rw_chk", 1'b1, 1'b0, 3'b010, 32'h108, 32'd0, 32'h55AA55AA, 0, 1);

    // Last in-range addresses, then the faults just beyond them.
    run_req("sw_top", 1'b0, 1'b1, 3'b010, 32'h3FFC, 32'hCAFEF00D, 32'd0, 0, 0);
    run_req("lw_top", 1'b1, 1'b0, 3'b010, 32'h3FFC, 32'd0, 32'hCAFEF00D, 0, 1);
    run_req("lbu_top", 1'b1, 1'b0, 3'b100, 32'h3FFF, 32'd0, 32'h000000CA, 0, 1);
    fault_req("lw_oor", 1'b1, 1'b0, 3'b010, 32'h3FFE);
    fault_req("lw_wrap", 1'b1, 1'b0, 3'b010, 32'hFFFFFFFE);
    fault_req("sw_badf3", 1'b0, 1'b1, 3'b011, 32'h100);
    fault_req("sb_oor", 1'b0, 1'b1, 3'b000, 32'h4000);

    // Flush in the second stall cycle: bytes at 0x301 and 0x302 only.
    run_req("sw_z300", 1'b0, 1'b1, 3'b010, 32'h300, 32'h00000000, 32'd0, 0, 0);
    run_req("sb_z304", 1'b0, 1'b1, 3'b000, 32'h304, 32'h00000000, 32'd0, 0, 0);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h301; req_wdata = 32'hAABBCCDD;
    #2;
    chk("fl_c1_stall", 32'(stall), 32'd1);
    @(negedge clk);
    flush = 1'b1;
    #2;
    chk("fl_c2_write", 32'(dm_mem_write), 32'd1);
    chk("fl_c2_addr", dm_addr, 32'h302);
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    #2;
    chk("fl_after_stall", 32'(stall), 32'd0);
    chk("fl_after_write", 32'(dm_mem_write), 32'd0);
    @(negedge clk);
    chk("fl_mem_303", 32'(mem[14'h303]), 32'h00);
    run_req("lw_fl", 1'b1, 1'b0, 3'b010, 32'h300, 32'd0, 32'h00CCDD00, 0, 1);

    // Reset in the second stall cycle: only the first byte lands.
    run_req("sw_z310", 1'b0, 1'b1, 3'b010, 32'h310, 32'h00000000, 32'd0, 0, 0);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h311; req_wdata = 32'hAABBCCDD;
    #2;
    chk("rs_c1_stall", 32'(stall), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #2;
    chk("rs_stall", 32'(stall), 32'd0);
    chk("rs_write", 32'(dm_mem_write), 32'd0);
    chk("rs_addr", dm_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    @(negedge clk);
    run_req("lw_rs", 1'b1, 1'b0, 3'b010, 32'h310, 32'd0, 32'h0000DD00, 0, 1);

    // Instance without misaligned support.
    nm_req_valid = 1'b1; nm_req_write = 1'b1; nm_req_funct3 = 3'b001; nm_req_addr = 32'h5; nm_req_wdata = 32'h0000BEEF;
    #2;
    chk("nm_sh5_fault", 32'(nm_access_fault), 32'd1);
    chk("nm_sh5_write", 32'(nm_dm_mem_write), 32'd0);
    chk("nm_sh5_stall", 32'(nm_stall), 32'd0);
    @(negedge clk);
    nm_req_addr = 32'h4;
    #2;
    chk("nm_sh4_fault", 32'(nm_access_fault), 32'd0);
    chk("nm_sh4_write", 32'(nm_dm_mem_write), 32'd1);
    chk("nm_sh4_addr", nm_dm_addr, 32'h4);
    chk("nm_sh4_wdata", nm_dm_wdata, 32'h0000BEEF);
    chk("nm_sh4_f3", nm_dm_instruction, 32'h00001000);
    @(negedge clk);
    nm_req_valid = 1'b0; nm_req_write = 1'b0;

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
- Sits directly upstream of the data memory in the MEM stage, between the EX/MEM pipeline register and the byte-addressed data memory.
- Aligned loads and stores pass straight through in the same cycle.
- Misaligned halfword and word accesses are split into sequential byte accesses. The pipeline is stalled while this happens, load bytes are reassembled, and the final result is sign- or zero-extended.
- Out-of-range and disallowed accesses are suppressed and flagged.

Parameters:
- MEM_BYTES, 16384: data memory size in bytes. An access is in range only if its last byte address is ≤ MEM_BYTES-1.
- ALLOW_MISALIGNED, 1: 1 = split misaligned accesses into byte accesses; 0 = suppress them and raise access_fault.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  the MEM-stage instruction is a load or store.
- req_read  in  1  load request.
- req_write  in  1  store request.
- req_funct3  in  3  RV32I load/store funct3.
- req_addr  in  32  effective address (ALU result).
- req_wdata  in  32  store data (rs2).
- flush  in  1  abort the current sequence.
- stall  out  1  hold the pipeline; upstream keeps all req_* inputs stable while this is 1.
- load_data  out  32  extended load result.
- load_valid  out  1  load_data is valid this cycle.
- access_fault  out  1  one-cycle pulse: access suppressed.
- dm_mem_read  out  1  to the data memory.
- dm_mem_write  out  1  to the data memory.
- dm_addr  out  32  to the data memory.
- dm_wdata  out  32  to the data memory.
- dm_instruction  out  32  funct3 carried in [14:12]; all other bits 0.
- dm_rdata  in  32  combinational read data from the data memory.

Behaviour:
- FSM states: IDLE, SPLIT, DONE. Registers: state, byte counter cnt[1:0], assembly register asm[31:0], latched size N.
- Reset (asynchronous): state=IDLE, cnt=0, asm=0.
  - While rst is high, all outputs are forced to 0, including dm_* and stall.
- Size N from funct3[1:0]: 00 → 1, 01 → 2, 10 → 4. Any other funct3 is invalid.
  - Invalid funct3 is a fault for a store. For a load, it produces no access and load_data=0, with no fault.
- Aligned: N=1, or N=2 with addr[0]=0, or N=4 with addr[1:0]=00.
- IDLE with an aligned, in-range request:
  - dm_* mirror the request combinationally: dm_addr=req_addr, dm_wdata=req_wdata, dm_instruction[14:12]=req_funct3.
  - load_data=dm_rdata, load_valid=req_read, stall=0. Zero added latency.
- Fault: access_fault=1 for one cycle, with no dm access, stall=0, load_valid=0. Conditions:
  - out of range: req_addr+N-1 ≥ MEM_BYTES, computed in 33-bit arithmetic so that wrap past 2^32 also faults;
  - misaligned with ALLOW_MISALIGNED=0;
  - invalid store funct3.
- IDLE with a misaligned, allowed request:
  - stall=1; issue byte 0 this cycle at dm_addr=req_addr.
  - Stores use funct3=000 (SB) with dm_wdata[7:0]=req_wdata byte 0. Loads use funct3=100 (LBU).
  - Capture the load byte into asm[7:0]; cnt←1; go to SPLIT.
- SPLIT:
  - stall=1; issue byte cnt at req_addr+cnt. The store byte is req_wdata[8*cnt+7 : 8*cnt]; the load byte goes to asm[8*cnt+7 : 8*cnt].
  - If cnt==N-1, go to DONE; otherwise cnt←cnt+1.
- DONE:
  - stall=0, no dm access.
  - For loads, load_valid=1 and load_data is:
    - LH: sign-extend asm[15:0] from bit 15;
    - LHU: zero-extend asm[15:0];
    - LW: asm.
  - Next state IDLE. The request still present in this cycle is treated as consumed and is not restarted.
- Misaligned latency is N+1 cycles: N stalled byte cycles plus the DONE cycle.
- flush in SPLIT or DONE: go to IDLE next edge, with no further dm access and no load_valid. Store bytes already written stay written.
  - flush in IDLE suppresses that cycle's access.
- rst asserted mid-sequence: go to IDLE immediately; the partial store is not completed.
- Both req_read and req_write high: treated as a store; load_valid=0.
- req_valid=0: all dm_* = 0, stall=0, load_valid=0, load_data=0.

Test Plan:
- Aligned SW to 0x100 with data 0xDEADBEEF, then LW from 0x100 → no stall; load_data=0xDEADBEEF in the same cycle as the request.
- SW 0x11223344 to 0x101 → stall high for 4 cycles; byte writes 0x44,0x33,0x22,0x11 to 0x101–0x104; DONE in cycle 5.
  - Then LW 0x101 → load_data=0x11223344, load_valid in cycle 5.
- Memory bytes 0x80 at 0x203 and 0xFF at 0x204:
  - LH 0x203 → 0xFFFFFF80 after 3 cycles;
  - LHU 0x203 → 0x0000FF80.
- LW at 0x3FFE with MEM_BYTES=16384 → access_fault pulse; no dm access; no stall.
  - LW at 0xFFFFFFFE also faults (wrap case).
- ALLOW_MISALIGNED=0: SH to 0x5 → access_fault=1, memory unchanged.
  - SH to 0x4 → normal write.
- Misaligned SW to 0x301 with flush in the 2nd stall cycle → only 2 bytes written (0x301 and 0x302); IDLE next cycle.
  - Repeat with rst instead of flush → outputs immediately 0; state IDLE.
